// File: rtl/frequency_meter.sv
// -----------------------------------------------------------------------------
// frequency_meter
//
// Equal-precision (reciprocal) frequency meter. A free-running preset generator
// produces a coarse gate (gate_pre). The real gate opens and closes on detected
// rising edges of clk_meas, so it always spans a whole number of clk_meas
// periods. Over that real gate the block counts clk_ref cycles (ref_out) and
// clk_meas periods (meas_out). Firmware derives
//   f_meas = f_ref * meas_out / ref_out.
//
// Ports
//   clk_ref    in   1      sole clock (reference)
//   sys_rstn   in   1      asynchronous active-low reset
//   clk_meas   in   1      signal under test, asynchronous, sampled by clk_ref
//   ref_out    out  CNT_W  clk_ref cycles spanned by the last real gate
//   meas_out   out  CNT_W  clk_meas periods spanned by the last real gate
//   start_ext  out  1      1-cycle pulse: real gate opened
//   stop_ext   out  1      1-cycle pulse: real gate closed, outputs updated
//   fsm_state  out  2      debug view of the control FSM
//                          (0 = WAIT_OPEN, 1 = MEAS, 2 = DONE)
// -----------------------------------------------------------------------------
module frequency_meter #(
    parameter int GATE_CYCLES = 100_000,
    parameter int GAP_CYCLES  = 10_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk_ref,
    input  logic             sys_rstn,
    input  logic             clk_meas,
    output logic [CNT_W-1:0] ref_out,
    output logic [CNT_W-1:0] meas_out,
    output logic             start_ext,
    output logic             stop_ext,
    output logic [1:0]       fsm_state
);

    localparam int PERIOD = GATE_CYCLES + GAP_CYCLES;
    localparam int PRE_W  = $clog2(PERIOD);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);
    localparam logic [PRE_W-1:0] GATE_END = PRE_W'(GATE_CYCLES);
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_OPEN = 2'd0,
        MEAS      = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // clk_meas synchroniser plus edge-detect flop. The same latency applies to
    // the opening and the closing edge, so it cancels out of ref_out.
    logic meas_s1, meas_s2, meas_s3;
    logic meas_rise;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            meas_s1 <= 1'b0;
            meas_s2 <= 1'b0;
            meas_s3 <= 1'b0;
        end else begin
            meas_s1 <= clk_meas;
            meas_s2 <= meas_s1;
            meas_s3 <= meas_s2;
        end
    end

    assign meas_rise = meas_s2 & ~meas_s3;

    // Preset generator: gate_pre is high for GATE_CYCLES, low for GAP_CYCLES.
    // gate_pre_d resets high so the first window after reset is not seen as a
    // fresh rising edge.
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_cnt_nxt;
    logic             gate_pre;
    logic             gate_pre_d;
    logic             gate_rise;

    assign pre_cnt_nxt = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_ONE;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            pre_cnt    <= '0;
            gate_pre   <= 1'b1;
            gate_pre_d <= 1'b1;
        end else begin
            pre_cnt    <= pre_cnt_nxt;
            gate_pre   <= (pre_cnt_nxt < GATE_END);
            gate_pre_d <= gate_pre;
        end
    end

    assign gate_rise = gate_pre & ~gate_pre_d;

    // FSM: state register
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state <= WAIT_OPEN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic. A measurement in MEAS stays open across later
    // preset windows until a clk_meas edge arrives with gate_pre low.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_OPEN: if (meas_rise && gate_pre)  state_nxt = MEAS;
            MEAS:      if (meas_rise && !gate_pre) state_nxt = DONE;
            DONE:      if (gate_rise)              state_nxt = WAIT_OPEN;
            default:                               state_nxt = WAIT_OPEN;
        endcase
    end

    // FSM: output decode. gate_pre is the registered value, so an edge that
    // coincides with the preset gate falling still counts inside the gate.
    logic open_gate;
    logic close_gate;
    logic count_meas;
    logic count_ref;

    always_comb begin
        open_gate  = 1'b0;
        close_gate = 1'b0;
        count_meas = 1'b0;
        count_ref  = 1'b0;
        case (state)
            WAIT_OPEN: open_gate = meas_rise & gate_pre;
            MEAS: begin
                count_ref  = 1'b1;
                count_meas = meas_rise & gate_pre;
                close_gate = meas_rise & ~gate_pre;
            end
            default: ;
        endcase
    end

    assign fsm_state = state;

    // Counters and results
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] meas_cnt;
    logic [CNT_W-1:0] ref_inc;

    // ref_cnt saturates rather than wrapping when clk_meas stalls mid-gate.
    assign ref_inc = (ref_cnt == CNT_MAX) ? ref_cnt : ref_cnt + CNT_ONE;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            ref_cnt   <= '0;
            meas_cnt  <= '0;
            ref_out   <= '0;
            meas_out  <= '0;
            start_ext <= 1'b0;
            stop_ext  <= 1'b0;
        end else begin
            start_ext <= open_gate;
            stop_ext  <= close_gate;
            if (open_gate) begin
                ref_cnt  <= '0;
                meas_cnt <= '0;
            end else begin
                if (count_ref) begin
                    ref_cnt <= ref_inc;
                end
                if (count_meas) begin
                    meas_cnt <= meas_cnt + CNT_ONE;
                end
            end
            // The closing edge itself completes one more period and one more
            // reference cycle than the counters hold at this point.
            if (close_gate) begin
                ref_out  <= ref_inc;
                meas_out <= meas_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_frequency_meter
//
// Directed bench for frequency_meter with a shortened preset (200-cycle gate,
// 40-cycle gap, 240-cycle period) and an 8-bit counter width so that
// saturation is reachable. clk_ref is 10 MHz (100 ns). clk_meas is started a
// fixed 3 cycles + 7 ns after reset release, so the first detected edge lands
// at a known cycle and integer-ratio cases have exact expected counts.
// -----------------------------------------------------------------------------
module tb_frequency_meter;

    localparam int GATE   = 200;
    localparam int GAP    = 40;
    localparam int PERIOD = GATE + GAP;
    localparam int W      = 8;
    localparam int REF_NS = 100;

    // clock / reset
    logic         clk_ref  = 1'b0;
    logic         sys_rstn = 1'b1;
    logic         clk_meas;
    logic [W-1:0] ref_out;
    logic [W-1:0] meas_out;
    logic         start_ext;
    logic         stop_ext;
    logic [1:0]   fsm_state;

    always #50 clk_ref = ~clk_ref;

    longint cyc = 0;
    always @(posedge clk_ref) cyc <= cyc + 1;

    // clk_meas generator: starts with a rising edge when enabled and always
    // finishes its current period low when disabled.
    bit meas_en   = 1'b0;
    int meas_half = 500;

    always begin
        clk_meas = 1'b0;
        wait (meas_en);
        while (meas_en) begin
            clk_meas = 1'b1;
            #(meas_half);
            clk_meas = 1'b0;
            #(meas_half);
        end
    end

    frequency_meter #(
        .GATE_CYCLES(GATE),
        .GAP_CYCLES (GAP),
        .CNT_W      (W)
    ) dut (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .clk_meas (clk_meas),
        .ref_out  (ref_out),
        .meas_out (meas_out),
        .start_ext(start_ext),
        .stop_ext (stop_ext),
        .fsm_state(fsm_state)
    );

    // scoreboard counters
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act,
                               input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // pulse tracking: every start must be followed by exactly one stop
    bit     gate_open_tb  = 1'b0;
    bit     saw_start     = 1'b0;
    bit     saw_stop      = 1'b0;
    int     n_start       = 0;
    int     n_stop        = 0;
    longint last_stop_cyc = 0;

    task automatic tick();
        @(negedge clk_ref);
        saw_start = 1'b0;
        saw_stop  = 1'b0;
        if (stop_ext) begin
            check("stop_after_start", longint'(gate_open_tb), 1);
            gate_open_tb  = 1'b0;
            n_stop++;
            saw_stop      = 1'b1;
            last_stop_cyc = cyc;
        end
        if (start_ext) begin
            check("start_stop_exclusive", longint'(stop_ext), 0);
            check("one_start_per_gate", longint'(gate_open_tb), 0);
            gate_open_tb = 1'b1;
            n_start++;
            saw_start    = 1'b1;
        end
    endtask

    task automatic wait_stop(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = saw_stop;
        end
        check("stop_within_budget", longint'(ok), 1);
    endtask

    task automatic wait_start(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = saw_start;
        end
        check("start_within_budget", longint'(ok), 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ref_out"},   longint'(ref_out),   0);
        check({tag, "_meas_out"},  longint'(meas_out),  0);
        check({tag, "_start_ext"}, longint'(start_ext), 0);
        check({tag, "_stop_ext"},  longint'(stop_ext),  0);
        check({tag, "_state"},     longint'(fsm_state), 0);
    endtask

    // Reset, check the reset state, release, then start clk_meas with the
    // given half period 3 cycles + 7 ns after release.
    task automatic do_reset(input int half_ns);
        meas_en = 1'b0;
        #7;
        sys_rstn = 1'b0;
        #2000;
        check_idle("reset");
        @(negedge clk_ref);
        sys_rstn     = 1'b1;
        gate_open_tb = 1'b0;
        meas_half    = half_ns;
        repeat (3) @(posedge clk_ref);
        #7;
        meas_en = 1'b1;
    endtask

    // stimulus table
    typedef struct {
        int half_ns;
        int meas_lo;
        int meas_hi;
        int tol_ns;
        bit chk_spacing;
    } vec_t;

    vec_t vecs[4];

    initial begin
        longint diff;
        longint prev_stop;
        int     s0;
        int     p0;

        // 1 MHz: exact 10:1, first edge never on a window boundary -> 20/200
        vecs[0] = '{half_ns: 500, meas_lo: 20, meas_hi: 20, tol_ns: 0,   chk_spacing: 1'b1};
        // f_ref/4: exact 4:1, first window 49 periods, later ones 50
        vecs[1] = '{half_ns: 200, meas_lo: 49, meas_hi: 50, tol_ns: 0,   chk_spacing: 1'b1};
        // 310 ns: non-integer ratio, +/-1 reference count
        vecs[2] = '{half_ns: 155, meas_lo: 63, meas_hi: 66, tol_ns: 100, chk_spacing: 1'b0};
        // 1.7 us: exact 17:1, phase drifts between windows
        vecs[3] = '{half_ns: 850, meas_lo: 11, meas_hi: 12, tol_ns: 0,   chk_spacing: 1'b0};

        #3;
        for (int v = 0; v < 4; v++) begin
            do_reset(vecs[v].half_ns);
            prev_stop = 0;
            for (int r = 0; r < 3; r++) begin
                wait_stop(3 * PERIOD);
                check_range("meas_out", longint'(meas_out), vecs[v].meas_lo, vecs[v].meas_hi);
                diff = longint'(ref_out) * REF_NS - longint'(meas_out) * (2 * vecs[v].half_ns);
                check_range("ref_vs_meas_ns", diff, -vecs[v].tol_ns, vecs[v].tol_ns);
                check("state_after_stop", longint'(fsm_state), 2);
                if (vecs[v].chk_spacing && r >= 2) begin
                    check("stop_spacing", last_stop_cyc - prev_stop, PERIOD);
                end
                prev_stop = last_stop_cyc;
            end
        end

        // clk_meas stops after one result: no more pulses, outputs hold
        do_reset(500);
        wait_stop(3 * PERIOD);
        check("first_ref_out",  longint'(ref_out),  200);
        check("first_meas_out", longint'(meas_out), 20);
        meas_en = 1'b0;
        s0 = n_start;
        p0 = n_stop;
        repeat (3 * PERIOD) tick();
        check("stalled_no_start", longint'(n_start - s0), 0);
        check("stalled_no_stop",  longint'(n_stop - p0),  0);
        check("held_ref_out",     longint'(ref_out),  200);
        check("held_meas_out",    longint'(meas_out), 20);
        check("stalled_state",    longint'(fsm_state), 0);

        // reset in the middle of a gate clears outputs at once
        do_reset(500);
        wait_stop(3 * PERIOD);
        check("pre_abort_ref_out", longint'(ref_out), 200);
        wait_start(2 * PERIOD);
        repeat (30) tick();
        check("mid_gate_state", longint'(fsm_state), 1);
        #13;
        sys_rstn = 1'b0;
        #1;
        check_idle("abort");
        do_reset(500);
        wait_stop(3 * PERIOD);
        check("after_abort_ref_out",  longint'(ref_out),  200);
        check("after_abort_meas_out", longint'(meas_out), 20);

        // clk_meas stalls inside a gate: measurement stays open, ref saturates
        do_reset(500);
        wait_start(2 * PERIOD);
        repeat (20) tick();
        meas_en = 1'b0;
        s0 = n_start;
        p0 = n_stop;
        repeat (3 * PERIOD) tick();
        check("open_no_stop",  longint'(n_stop - p0),  0);
        check("open_no_start", longint'(n_start - s0), 0);
        check("open_state",    longint'(fsm_state), 1);
        @(posedge clk_ref);
        #7;
        meas_en = 1'b1;
        wait_stop(3 * PERIOD);
        check("saturated_ref_out", longint'(ref_out), 255);
        check("saturated_state",   longint'(fsm_state), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
